// File: rtl/player_ctrl.sv
// ---------------------------------------------------------------------------
// player_ctrl
// Per-player paddle motion controller. The paddle advances at most once per
// video frame, on the rising edge of VS in the RGB stream. Speed ramps while
// one direction is held, and travel is clamped to [POS_MIN, POS_MAX].
//
// Optional feature (macro PLAYER_CTRL_AUTO_EN): adds auto_i / target_i. With
// auto_i high the buttons are ignored and the paddle tracks target_i.
//
// Ports:
//   px_clk    in   1  pixel clock
//   rst_n     in   1  asynchronous active-low reset
//   strRGB_i  in  26  RGB stream, only bit 1 (VS) is used
//   btn_up    in   1  async button, move toward POS_MIN
//   btn_down  in   1  async button, move toward POS_MAX
//   auto_i    in   1  (PLAYER_CTRL_AUTO_EN only) auto-tracking enable
//   target_i  in  10  (PLAYER_CTRL_AUTO_EN only) ball Y to track
//   pos       out 10  paddle position
//   dir       out  2  00 STOP, 01 UP, 10 DOWN
//   speed     out  4  current step size
//   at_limit  out  1  pos is at POS_MIN or POS_MAX
//
// state | meaning
// ------+--------------------------------------------
// STOP  | no movement requested, speed held at 1
// UP    | moving toward POS_MIN
// DOWN  | moving toward POS_MAX
// ---------------------------------------------------------------------------
module player_ctrl #(
  parameter int POS_RESET    = 260,
  parameter int POS_MIN      = 0,
  parameter int POS_MAX      = 520,
  parameter int MAX_SPEED    = 8,
  parameter int ACCEL_FRAMES = 4,
  parameter int PLAYER_SIZE  = 80,
  parameter int DEADBAND     = 4
) (
  input  logic        px_clk,
  input  logic        rst_n,
  input  logic [25:0] strRGB_i,
  input  logic        btn_up,
  input  logic        btn_down,
`ifdef PLAYER_CTRL_AUTO_EN
  input  logic        auto_i,
  input  logic [9:0]  target_i,
`endif
  output logic [9:0]  pos,
  output logic [1:0]  dir,
  output logic [3:0]  speed,
  output logic        at_limit
);

  generate
    if (!(POS_MIN <= POS_RESET && POS_RESET <= POS_MAX)) begin : g_bad_reset
      $error("player_ctrl: POS_RESET must lie within POS_MIN..POS_MAX");
    end
    if (MAX_SPEED < 1 || MAX_SPEED > 15) begin : g_bad_speed
      $error("player_ctrl: MAX_SPEED must be 1..15");
    end
    if (ACCEL_FRAMES < 1) begin : g_bad_accel
      $error("player_ctrl: ACCEL_FRAMES must be >= 1");
    end
    if (PLAYER_SIZE < 0 || DEADBAND < 0) begin : g_bad_auto
      $error("player_ctrl: PLAYER_SIZE and DEADBAND must be non-negative");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_STOP = 2'b00,
    ST_UP   = 2'b01,
    ST_DOWN = 2'b10
  } state_t;

  localparam int HW = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(ACCEL_FRAMES - 1);
  localparam logic [10:0]   MIN11     = 11'(POS_MIN);
  localparam logic [10:0]   MAX11     = 11'(POS_MAX);
  localparam logic [9:0]    RST10     = 10'(POS_RESET);
  localparam logic [3:0]    MAXSPD4   = 4'(MAX_SPEED);
  localparam logic          LIM_RST   = (POS_RESET == POS_MIN) || (POS_RESET == POS_MAX);

  logic          r_up_m, r_up_s, r_dn_m, r_dn_s;
  logic          r_vs_d;
  state_t        r_dir, w_dir_nxt;
  logic [9:0]    r_pos, w_pos_nxt;
  logic [3:0]    r_speed, w_speed_nxt;
  logic [HW-1:0] r_hold, w_hold_nxt;
  logic          r_at_limit, w_lim_nxt;

  logic          w_tick;
  state_t        w_req;
  logic [10:0]   w_step, w_pos11, w_moved;
  logic          w_clamp;
  logic          w_unused_rgb;

  assign w_unused_rgb = ^{strRGB_i[25:2], strRGB_i[0]};
  assign w_tick       = strRGB_i[1] & ~r_vs_d;

  // Request decode; buttons pressed together cancel out
`ifdef PLAYER_CTRL_AUTO_EN
  logic [11:0] w_ctr, w_tgt;
  assign w_ctr = {2'b00, r_pos} + 12'(PLAYER_SIZE / 2);
  assign w_tgt = {2'b00, target_i};
`endif

  always_comb begin
    w_req = ST_STOP;
`ifdef PLAYER_CTRL_AUTO_EN
    if (auto_i) begin
      if (w_tgt > w_ctr + 12'(DEADBAND))      w_req = ST_DOWN;
      else if (w_tgt + 12'(DEADBAND) < w_ctr) w_req = ST_UP;
      else                                    w_req = ST_STOP;
    end else
`endif
    if (r_up_s && !r_dn_s)      w_req = ST_UP;
    else if (r_dn_s && !r_up_s) w_req = ST_DOWN;
    else                        w_req = ST_STOP;
  end

  // Candidate move, 11-bit so that neither limit can wrap
  always_comb begin
    w_step  = (w_req == r_dir) ? {7'd0, r_speed} : 11'd1;
    w_pos11 = {1'b0, r_pos};
    w_moved = w_pos11;
    w_clamp = 1'b0;
    if (w_req == ST_UP) begin
      if (w_pos11 < MIN11 + w_step) begin
        w_moved = MIN11;
        w_clamp = 1'b1;
      end else begin
        w_moved = w_pos11 - w_step;
      end
    end else if (w_req == ST_DOWN) begin
      if (w_pos11 + w_step > MAX11) begin
        w_moved = MAX11;
        w_clamp = 1'b1;
      end else begin
        w_moved = w_pos11 + w_step;
      end
    end
  end

  // State register
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_up_m     <= 1'b0;
      r_up_s     <= 1'b0;
      r_dn_m     <= 1'b0;
      r_dn_s     <= 1'b0;
      r_vs_d     <= 1'b0;
      r_dir      <= ST_STOP;
      r_pos      <= RST10;
      r_speed    <= 4'd1;
      r_hold     <= '0;
      r_at_limit <= LIM_RST;
    end else begin
      r_up_m     <= btn_up;
      r_up_s     <= r_up_m;
      r_dn_m     <= btn_down;
      r_dn_s     <= r_dn_m;
      r_vs_d     <= strRGB_i[1];
      r_dir      <= w_dir_nxt;
      r_pos      <= w_pos_nxt;
      r_speed    <= w_speed_nxt;
      r_hold     <= w_hold_nxt;
      r_at_limit <= w_lim_nxt;
    end
  end

  // Next state; everything holds between frame ticks
  always_comb begin
    w_dir_nxt   = r_dir;
    w_pos_nxt   = r_pos;
    w_speed_nxt = r_speed;
    w_hold_nxt  = r_hold;
    w_lim_nxt   = r_at_limit;
    if (w_tick) begin
      if (w_req == ST_STOP) begin
        w_dir_nxt   = ST_STOP;
        w_speed_nxt = 4'd1;
        w_hold_nxt  = '0;
      end else begin
        w_dir_nxt = w_req;
        w_pos_nxt = w_moved[9:0];
        // Start, reversal or hitting a wall all restart the ramp
        if (w_req != r_dir || w_clamp) begin
          w_speed_nxt = 4'd1;
          w_hold_nxt  = '0;
        end else if (r_hold == HOLD_LAST) begin
          w_hold_nxt  = '0;
          w_speed_nxt = (r_speed >= MAXSPD4) ? MAXSPD4 : r_speed + 4'd1;
        end else begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end
      w_lim_nxt = (w_pos_nxt == MIN11[9:0]) || (w_pos_nxt == MAX11[9:0]);
    end
  end

  // Outputs
  always_comb begin
    pos      = r_pos;
    dir      = r_dir;
    speed    = r_speed;
    at_limit = r_at_limit;
  end

endmodule
